// File: rtl/lockstep_pkg.sv
// -----------------------------------------------------------------------------
// lockstep_pkg
//   Shared types for the lockstep retire-trace comparator.
//   - fail_cause_e : encoding of the fail_cause output (CAUSE_* values)
//   - state_e      : checker state, RUN while comparing, FAIL once diverged
// -----------------------------------------------------------------------------
package lockstep_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISMATCH = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } fail_cause_e;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_FAIL = 1'b1
  } state_e;

endpackage : lockstep_pkg

// File: rtl/lockstep_fifo.sv
// -----------------------------------------------------------------------------
// lockstep_fifo
//   Synchronous FIFO holding one side's retire-trace records.
//   Pointers carry an extra wrap bit so full and empty are distinguishable
//   without a separate occupancy counter.
// Ports
//   clk, rst_n  clock, async active-low reset
//   push        write push_data at the edge (ignored when full unless popping)
//   push_data   record to store
//   pop         discard the head at the edge (ignored when empty)
//   flush       empty the FIFO at the edge; wins over push and pop
//   full/empty  status
//   head        oldest stored record, valid when !empty
// -----------------------------------------------------------------------------
module lockstep_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so push on full is fine then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // meaningful, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

endmodule : lockstep_fifo

// File: rtl/lockstep_trace_cmp.sv
// -----------------------------------------------------------------------------
// lockstep_trace_cmp
//   Lockstep checker: buffers reference and DUT retire-trace streams, compares
//   them in order under cmp_mask, and flags the first divergence (data
//   mismatch, or one side producing records while the other stays silent).
// Ports
//   clk, rst_n              clock, async active-low reset
//   enable                  0: records accepted and discarded, no compare
//   clear                   synchronous flush of FIFOs, counters and status
//   cmp_mask                1 = bit participates in the compare
//   ref_valid/data/ready    reference record handshake
//   dut_valid/data/ready    DUT record handshake
//   match_count             records compared equal (saturating)
//   fail, fail_cause        sticky divergence flag and its cause
//   fail_index              match_count at the failure = bad record index
//   fail_ref, fail_dut      heads captured at the failure (0 if that side empty)
// -----------------------------------------------------------------------------
module lockstep_trace_cmp
  import lockstep_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] cmp_mask,
  input  logic              ref_valid,
  input  logic [DATA_W-1:0] ref_data,
  output logic              ref_ready,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_data,
  output logic              dut_ready,
  output logic [CNT_W-1:0]  match_count,
  output logic              fail,
  output logic [1:0]        fail_cause,
  output logic [CNT_W-1:0]  fail_index,
  output logic [DATA_W-1:0] fail_ref,
  output logic [DATA_W-1:0] fail_dut
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  fail_cause_e       cause_q, cause_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] cap_ref_q, cap_ref_d;
  logic [DATA_W-1:0] cap_dut_q, cap_dut_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              live_q;

  logic              accept_en;
  logic              fifo_flush;
  logic              ref_push, dut_push;
  logic              ref_full, ref_empty, dut_full, dut_empty;
  logic [DATA_W-1:0] ref_head, dut_head;
  logic              pop;
  logic              mismatch;
  logic              one_side;
  logic              timeout_hit;

  // live_q holds ready low throughout reset and releases it one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  assign accept_en = live_q && (state_q == ST_RUN) && enable;

  // Outside active compare the checker swallows records so it never stalls
  // a core that is still running.
  assign ref_ready = live_q && (!accept_en || !ref_full);
  assign dut_ready = live_q && (!accept_en || !dut_full);

  assign ref_push   = ref_valid && ref_ready && accept_en && !clear;
  assign dut_push   = dut_valid && dut_ready && accept_en && !clear;
  assign fifo_flush = clear || !accept_en;

  lockstep_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ref_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ref_push),
    .push_data (ref_data),
    .pop       (pop),
    .flush     (fifo_flush),
    .full      (ref_full),
    .empty     (ref_empty),
    .head      (ref_head)
  );

  lockstep_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dut_push),
    .push_data (dut_data),
    .pop       (pop),
    .flush     (fifo_flush),
    .full      (dut_full),
    .empty     (dut_empty),
    .head      (dut_head)
  );

  assign pop         = accept_en && !ref_empty && !dut_empty;
  assign mismatch    = pop && (|((ref_head ^ dut_head) & cmp_mask));
  assign one_side    = ref_empty ^ dut_empty;
  assign timeout_hit = accept_en && one_side && (tmo_q == TMO_W'(TIMEOUT - 1));

  // NOTE: every next-state signal gets its hold value first, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    match_d   = match_q;
    index_d   = index_q;
    cap_ref_d = cap_ref_q;
    cap_dut_d = cap_dut_q;
    tmo_d     = tmo_q;

    if (clear) begin
      state_d   = ST_RUN;
      cause_d   = CAUSE_NONE;
      match_d   = '0;
      index_d   = '0;
      cap_ref_d = '0;
      cap_dut_d = '0;
      tmo_d     = '0;
    end else if (state_q == ST_RUN) begin
      if (!accept_en || pop || !one_side) tmo_d = '0;
      else                                tmo_d = tmo_q + TMO_W'(1);

      // Mismatch is checked first: it wins if both could fire together.
      if (mismatch) begin
        state_d   = ST_FAIL;
        cause_d   = CAUSE_MISMATCH;
        index_d   = match_q;
        cap_ref_d = ref_head;
        cap_dut_d = dut_head;
      end else if (timeout_hit) begin
        state_d   = ST_FAIL;
        cause_d   = CAUSE_TIMEOUT;
        index_d   = match_q;
        cap_ref_d = ref_empty ? '0 : ref_head;
        cap_dut_d = dut_empty ? '0 : dut_head;
      end else if (pop && (match_q != '1)) begin
        match_d = match_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cause_q   <= CAUSE_NONE;
      match_q   <= '0;
      index_q   <= '0;
      cap_ref_q <= '0;
      cap_dut_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      match_q   <= match_d;
      index_q   <= index_d;
      cap_ref_q <= cap_ref_d;
      cap_dut_q <= cap_dut_d;
      tmo_q     <= tmo_d;
    end
  end

  assign match_count = match_q;
  assign fail        = (state_q == ST_FAIL);
  assign fail_cause  = cause_q;
  assign fail_index  = index_q;
  assign fail_ref    = cap_ref_q;
  assign fail_dut    = cap_dut_q;

endmodule : lockstep_trace_cmp
